// File: rtl/snow64_memory_bus_responder.sv
// Line-wide backing RAM answering the memory bus guard: one request at a time,
// completion signalled by a one-cycle out_valid pulse a fixed LATENCY cycles later.
module snow64_memory_bus_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mem_acc_type,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_busy
);

  // Handshake: in_req is a strobe taken at any rising edge outside StWait
  // (no ready back to the guard); out_valid is high for exactly one cycle per
  // accepted request and out_data is meaningful only while it is high.

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRespond = 2'd2
  } state_t;

  state_t state, stateNext;
  logic [3:0] counter, counterNext;
  logic [DATA_WIDTH-1:0] dataReg;
  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DEPTH_LOG2-1:0] lineIdx;
  logic accept;
  logic unusedAddrBits;

  // Byte offset within the line and bits above the RAM depth are dropped, so
  // addresses alias modulo the number of lines.
  assign lineIdx = in_addr[5+DEPTH_LOG2-1:5];
  assign unusedAddrBits = ^{in_addr[ADDR_WIDTH-1:5+DEPTH_LOG2], in_addr[4:0]};

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    accept      = 1'b0;
    case (state)
      StIdle, StRespond: begin
        if (in_req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            stateNext = StRespond;
          end else begin
            stateNext   = StWait;
            counterNext = LatM1;
          end
        end else begin
          stateNext = StIdle;
        end
      end
      StWait: begin
        counterNext = counter - 4'd1;
        if (counter == 4'd1) stateNext = StRespond;
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      counter <= 4'd0;
      dataReg <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      if (accept) dataReg <= in_mem_acc_type ? '0 : mem[lineIdx];
    end
  end

  // RAM is never cleared; a write commits on its own acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst && accept && in_mem_acc_type) mem[lineIdx] <= in_data;
  end

  assign out_valid = (state == StRespond);
  assign out_data  = (state == StRespond) ? dataReg : '0;
  assign out_busy  = (state == StWait);

endmodule
